// File: rtl/score_digit_renderer.sv
// score_digit_renderer
// Converts a binary score to BCD with a sequential double-dabble engine and
// renders the digits as scaled 8x8 glyphs with leading-zero blanking.
// Render path: two registered stages from pixel coordinates to pix_on.
module score_digit_renderer #(
  parameter int DIGITS        = 4,
  parameter int VALUE_W       = 14,
  parameter int SCALE_SHIFT   = 1,
  parameter int BLANK_LEADING = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [VALUE_W-1:0] value,
  input  logic               value_load,
  output logic               busy,
  output logic               overflow,
  input  logic [10:0]        origin_x,
  input  logic [9:0]         origin_y,
  input  logic [10:0]        pix_x,
  input  logic [9:0]         pix_y,
  input  logic               pix_valid,
  output logic               pix_on,
  output logic               pix_on_valid
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + VALUE_W;
  localparam int CNT_W = $clog2(VALUE_W + 1);
  localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BOX_W = (DIGITS * 8) << SCALE_SHIFT;
  localparam int BOX_H = 8 << SCALE_SHIFT;

  // 10^n evaluated at elaboration time for the saturation limit.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int k = 0; k < n; k++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

  localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;

  // One glyph row of the 8x8 digit font; MSB is the leftmost pixel.
  // Non-decimal codes map to an empty glyph.
  function automatic logic [7:0] font_row(input logic [3:0] d, input logic [2:0] r);
    logic [63:0] g;
    case (d)
      4'd0:    g = 64'h3C66666666663C00;
      4'd1:    g = 64'h183818181818_7E00;
      4'd2:    g = 64'h3C66060C30607E00;
      4'd3:    g = 64'h3C66061C06663C00;
      4'd4:    g = 64'h0C1C3C6C7E0C1E00;
      4'd5:    g = 64'h7E607C0606663C00;
      4'd6:    g = 64'h3C66607C66663C00;
      4'd7:    g = 64'h7E66060C18181800;
      4'd8:    g = 64'h3C66663C66663C00;
      4'd9:    g = 64'h3C66663E06663C00;
      default: g = 64'h0;
    endcase
    g = g << {r, 3'b000};
    return g[63:56];
  endfunction

  // ---------------------------------------------------------------------
  // Conversion engine
  // ---------------------------------------------------------------------
  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    COMMIT
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   iter_q, iter_d;
  logic [SR_W-1:0]    sr_q, sr_d;
  logic               pend_ovf_q, pend_ovf_d;
  logic [BCD_W-1:0]   disp_q, disp_d;
  logic               overflow_q, overflow_d;

  logic [63:0]        value_ext;
  logic               value_ovf;
  logic [VALUE_W-1:0] value_sat;
  logic [SR_W-1:0]    sr_adj;
  logic [SR_W-1:0]    sr_shift;

  // Values that cannot be shown are clamped to all nines.
  assign value_ext = 64'(value);
  assign value_ovf = (value_ext > MAX_VAL);
  assign value_sat = value_ovf ? MAX_VAL[VALUE_W-1:0] : value;

  // Add-3 correction on every BCD nibble, then one shift per iteration.
  assign sr_adj[VALUE_W-1:0] = sr_q[VALUE_W-1:0];
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dabble
    logic [3:0] nib;
    assign nib = sr_q[VALUE_W + 4*gi +: 4];
    assign sr_adj[VALUE_W + 4*gi +: 4] = (nib >= 4'd5) ? (nib + 4'd3) : nib;
  end
  assign sr_shift = sr_adj << 1;

  // Conversion FSM and display register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      iter_q     <= '0;
      sr_q       <= '0;
      pend_ovf_q <= 1'b0;
      disp_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      iter_q     <= iter_d;
      sr_q       <= sr_d;
      pend_ovf_q <= pend_ovf_d;
      disp_q     <= disp_d;
      overflow_q <= overflow_d;
    end
  end

  // Next-state logic: load in IDLE, VALUE_W dabble steps, one commit cycle.
  always_comb begin
    state_d    = state_q;
    iter_d     = iter_q;
    sr_d       = sr_q;
    pend_ovf_d = pend_ovf_q;
    disp_d     = disp_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE: begin
        if (value_load) begin
          sr_d       = {{BCD_W{1'b0}}, value_sat};
          pend_ovf_d = value_ovf;
          iter_d     = '0;
          state_d    = CONVERT;
        end
      end
      CONVERT: begin
        sr_d   = sr_shift;
        iter_d = iter_q + CNT_W'(1);
        if (iter_q == CNT_W'(VALUE_W - 1)) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        disp_d     = sr_q[SR_W-1 -: BCD_W];
        overflow_d = pend_ovf_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign overflow = overflow_q;

  // ---------------------------------------------------------------------
  // Digit view of the display register, index 0 = leftmost digit
  // ---------------------------------------------------------------------
  logic [3:0]        digit_nib [DIGITS];
  logic [DIGITS-1:0] lead_zero;
  logic [DIGITS-1:0] blank;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digits
    assign digit_nib[gi] = disp_q[4*(DIGITS-1-gi) +: 4];
    if (gi == 0) begin : g_first
      assign lead_zero[gi] = (digit_nib[gi] == 4'd0);
    end else begin : g_rest
      assign lead_zero[gi] = (digit_nib[gi] == 4'd0) && lead_zero[gi-1];
    end
    // The rightmost digit is always drawn so a zero score shows "0".
    assign blank[gi] = (BLANK_LEADING != 0) && (gi != DIGITS - 1) && lead_zero[gi];
  end

  // ---------------------------------------------------------------------
  // Render stage 1: box test and field decode
  // ---------------------------------------------------------------------
  logic signed [11:0] dx;
  logic signed [10:0] dy;
  logic               in_box;

  logic               s1_valid_q, s1_valid_d;
  logic               s1_hit_q, s1_hit_d;
  logic [DIG_W-1:0]   s1_digit_q, s1_digit_d;
  logic [2:0]         s1_row_q, s1_row_d;
  logic [2:0]         s1_col_q, s1_col_d;

  assign dx = $signed({1'b0, pix_x} - {1'b0, origin_x});
  assign dy = $signed({1'b0, pix_y} - {1'b0, origin_y});

  assign in_box = !dx[11] && !dy[10] &&
                  ($unsigned(dx) < 12'(BOX_W)) &&
                  ($unsigned(dy) < 11'(BOX_H));

  // Stage 1 decode of the incoming pixel against the sampled origin.
  always_comb begin
    s1_valid_d = pix_valid;
    s1_hit_d   = pix_valid && in_box;
    s1_digit_d = dx[3+SCALE_SHIFT +: DIG_W];
    s1_col_d   = dx[SCALE_SHIFT +: 3];
    s1_row_d   = dy[SCALE_SHIFT +: 3];
  end

  // Stage 1 pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_hit_q   <= 1'b0;
      s1_digit_q <= '0;
      s1_row_q   <= '0;
      s1_col_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_hit_q   <= s1_hit_d;
      s1_digit_q <= s1_digit_d;
      s1_row_q   <= s1_row_d;
      s1_col_q   <= s1_col_d;
    end
  end

  // ---------------------------------------------------------------------
  // Render stage 2: font lookup
  // ---------------------------------------------------------------------
  logic [3:0] sel_nib;
  logic       sel_blank;
  logic [7:0] row_bits;
  logic       pix_on_q, pix_on_d;
  logic       pix_on_valid_q, pix_on_valid_d;

  // Select the addressed digit and fetch its glyph bit.
  always_comb begin
    sel_nib   = 4'd0;
    sel_blank = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (s1_digit_q == DIG_W'(i)) begin
        sel_nib   = digit_nib[i];
        sel_blank = blank[i];
      end
    end
    row_bits       = font_row(sel_nib, s1_row_q);
    pix_on_d       = s1_hit_q && !sel_blank && row_bits[3'd7 - s1_col_q];
    pix_on_valid_d = s1_valid_q;
  end

  // Stage 2 output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_on_q       <= 1'b0;
      pix_on_valid_q <= 1'b0;
    end else begin
      pix_on_q       <= pix_on_d;
      pix_on_valid_q <= pix_on_valid_d;
    end
  end

  assign pix_on       = pix_on_q;
  assign pix_on_valid = pix_on_valid_q;

endmodule

// File: tb/tb_score_digit_renderer.sv
// Bench for score_digit_renderer: a cycle-level behavioural model (decimal
// arithmetic and a busy countdown) checked every cycle, plus literal probes.
module tb_score_digit_renderer;

  localparam int DIGITS        = 4;
  localparam int VALUE_W       = 14;
  localparam int SCALE_SHIFT   = 1;
  localparam int BLANK_LEADING = 1;
  localparam int SC            = 1 << SCALE_SHIFT;
  localparam int BOX_W         = DIGITS * 8 * SC;
  localparam int BOX_H         = 8 * SC;

  logic               clk;
  logic               rst_n;
  logic [VALUE_W-1:0] value;
  logic               value_load;
  logic               busy;
  logic               overflow;
  logic [10:0]        origin_x;
  logic [9:0]         origin_y;
  logic [10:0]        pix_x;
  logic [9:0]         pix_y;
  logic               pix_valid;
  logic               pix_on;
  logic               pix_on_valid;

  score_digit_renderer #(
    .DIGITS(DIGITS), .VALUE_W(VALUE_W),
    .SCALE_SHIFT(SCALE_SHIFT), .BLANK_LEADING(BLANK_LEADING)
  ) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .value_load(value_load),
    .busy(busy), .overflow(overflow),
    .origin_x(origin_x), .origin_y(origin_y),
    .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
    .pix_on(pix_on), .pix_on_valid(pix_on_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] font [10][8] = '{
    '{8'h3C, 8'h66, 8'h66, 8'h66, 8'h66, 8'h66, 8'h3C, 8'h00},
    '{8'h18, 8'h38, 8'h18, 8'h18, 8'h18, 8'h18, 8'h7E, 8'h00},
    '{8'h3C, 8'h66, 8'h06, 8'h0C, 8'h30, 8'h60, 8'h7E, 8'h00},
    '{8'h3C, 8'h66, 8'h06, 8'h1C, 8'h06, 8'h66, 8'h3C, 8'h00},
    '{8'h0C, 8'h1C, 8'h3C, 8'h6C, 8'h7E, 8'h0C, 8'h1E, 8'h00},
    '{8'h7E, 8'h60, 8'h7C, 8'h06, 8'h06, 8'h66, 8'h3C, 8'h00},
    '{8'h3C, 8'h66, 8'h60, 8'h7C, 8'h66, 8'h66, 8'h3C, 8'h00},
    '{8'h7E, 8'h66, 8'h06, 8'h0C, 8'h18, 8'h18, 8'h18, 8'h00},
    '{8'h3C, 8'h66, 8'h66, 8'h3C, 8'h66, 8'h66, 8'h3C, 8'h00},
    '{8'h3C, 8'h66, 8'h66, 8'h3E, 8'h06, 8'h66, 8'h3C, 8'h00}
  };

  function automatic int p10(input int n);
    int r;
    r = 1;
    for (int k = 0; k < n; k++) r = r * 10;
    return r;
  endfunction

  localparam int MAXV = 9999;

  // Expected glyph bit of a screen pixel for a displayed decimal value.
  function automatic int exp_pix(input int x, input int y, input int ox, input int oy,
                                 input int valid, input int disp);
    int dx, dy, d, col, row, lead, dig;
    if (valid == 0) return 0;
    dx = x - ox;
    dy = y - oy;
    if (dx < 0 || dx >= BOX_W || dy < 0 || dy >= BOX_H) return 0;
    d    = dx / (8 * SC);
    col  = (dx / SC) % 8;
    row  = (dy / SC) % 8;
    lead = disp / p10(DIGITS - 1 - d);
    dig  = lead % 10;
    if (BLANK_LEADING != 0 && d != DIGITS - 1 && lead == 0) return 0;
    return int'(font[dig][row][7 - col]);
  endfunction

  typedef struct {
    int x; int y; int ox; int oy; int valid; int disp_a; int disp_b;
  } pix_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  bit   started  = 1'b0;

  // Model state
  int   m_disp = 0, m_ovf = 0, m_busy = 0, m_pend = 0, m_pend_ovf = 0;
  pix_t p1, p2;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_disp = 0; m_ovf = 0; m_busy = 0; m_pend = 0; m_pend_ovf = 0;
    p1 = '{default: 0};
    p2 = '{default: 0};
  endtask

  // Per-cycle compare against the model, then advance the model by the
  // edge about to come (inputs are stable from posedge+1 to next posedge).
  always @(negedge clk) begin
    if (started) begin
      int ea, eb;
      if (!rst_n) model_reset();
      chk("busy", int'(busy), (m_busy > 0) ? 1 : 0);
      chk("overflow", int'(overflow), m_ovf);
      chk("pix_on_valid", int'(pix_on_valid), p2.valid);
      ea = exp_pix(p2.x, p2.y, p2.ox, p2.oy, p2.valid, p2.disp_a);
      eb = exp_pix(p2.x, p2.y, p2.ox, p2.oy, p2.valid, p2.disp_b);
      n_checks++;
      if (int'(pix_on) != ea && int'(pix_on) != eb) begin
        n_fail++;
        $display("FAIL pix_on: got %0d, expected %0d at (%0d,%0d) (t=%0t)",
                 pix_on, ea, p2.x, p2.y, $time);
      end
      if (rst_n) begin
        p2 = p1;
        p1.x = int'(pix_x);   p1.y = int'(pix_y);
        p1.ox = int'(origin_x); p1.oy = int'(origin_y);
        p1.valid = int'(pix_valid);
        p1.disp_a = m_disp;   p1.disp_b = m_disp;
        if (m_busy > 0) begin
          m_busy--;
          if (m_busy == 0) begin
            m_disp = m_pend;
            m_ovf  = m_pend_ovf;
          end
        end else if (value_load) begin
          m_busy = VALUE_W + 1;
          if (int'(value) > MAXV) begin
            m_pend = MAXV; m_pend_ovf = 1;
          end else begin
            m_pend = int'(value); m_pend_ovf = 0;
          end
        end
        p2.disp_b = m_disp;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic probe(input int x, input int y, input int v, input int exp_on,
                       input string name);
    pix_x = 11'(x); pix_y = 10'(y); pix_valid = v[0];
    tick();
    tick();
    chk({name, "_on"}, int'(pix_on), exp_on);
    chk({name, "_vld"}, int'(pix_on_valid), v);
    $display("probe %s (%0d,%0d) valid=%0d pix_on=%0d", name, x, y, v, pix_on);
  endtask

  task automatic load(input int v);
    value = VALUE_W'(v);
    value_load = 1'b1;
    tick();
    value_load = 1'b0;
    $display("load %0d", v);
  endtask

  task automatic wait_idle(input string name);
    int i;
    i = 0;
    while (busy && i < 60) begin
      tick();
      i++;
    end
    chk({name, "_idle"}, int'(busy), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, xi, yi, ox, oy;
    rst_n = 1'b1; value = '0; value_load = 1'b0;
    origin_x = 11'd100; origin_y = 10'd50;
    pix_x = '0; pix_y = '0; pix_valid = 1'b0;
    p1 = '{default: 0};
    p2 = '{default: 0};
    #2;
    rst_n = 1'b0;
    started = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_ovf", int'(overflow), 0);

    // Zero score shows a single "0" in the rightmost digit.
    probe(152, 50, 1, 1, "rst_d3");
    probe(104, 50, 1, 0, "rst_d0_blank");

    // 1234: busy length and glyph bits.
    load(1234);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) cnt++;
      else if (cnt > 0) break;
      tick();
    end
    chk("busy_len", cnt, 15);
    chk("ovf_1234", int'(overflow), 0);
    probe(104, 52, 1, 1, "d1_r1c2");
    probe(114, 52, 1, 0, "d1_r1c7");
    probe(156, 50, 1, 1, "d4_r0c4");

    // Saturation then recovery.
    load(12000);
    wait_idle("sat");
    chk("ovf_sat", int'(overflow), 1);
    probe(104, 50, 1, 1, "sat_d0");
    load(5);
    wait_idle("five");
    chk("ovf_five", int'(overflow), 0);
    probe(104, 50, 1, 0, "five_d0_blank");
    probe(150, 50, 1, 1, "five_d3");

    // Load while busy is dropped; old digits stay up during conversion.
    load(42);
    tick();
    tick();
    load(7);
    probe(150, 50, 1, 1, "busy_old_digits");
    wait_idle("q42");
    repeat (3) tick();
    chk("no_requeue", int'(busy), 0);
    probe(140, 50, 1, 1, "d42_digit2");
    probe(150, 50, 1, 0, "d42_digit3");

    // Box edges and invalid pixels.
    probe(99, 50, 1, 0, "left_edge");
    probe(164, 50, 1, 0, "right_edge");
    probe(152, 66, 1, 0, "bottom_edge");
    probe(152, 50, 0, 0, "not_valid");

    // Reset in the middle of a conversion.
    load(9999);
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_ovf", int'(overflow), 0);
    chk("midrst_vld", int'(pix_on_valid), 0);
    repeat (3) tick();
    rst_n = 1'b1;
    probe(152, 50, 1, 1, "after_rst_d3");
    probe(104, 50, 1, 0, "after_rst_d0");
    repeat (20) tick();
    probe(104, 50, 1, 0, "no_late_commit");

    // Randomised traffic against the model.
    ox = 100; oy = 50;
    for (int i = 0; i < 1500; i++) begin
      if (i % 60 == 0) begin
        ox = $urandom_range(0, 1950);
        oy = $urandom_range(0, 1000);
        origin_x = 11'(ox); origin_y = 10'(oy);
      end
      xi = ox + $urandom_range(0, BOX_W + 6) - 3;
      yi = oy + $urandom_range(0, BOX_H + 4) - 2;
      if (xi < 0) xi = 0;
      if (xi > 2047) xi = 2047;
      if (yi < 0) yi = 0;
      if (yi > 1023) yi = 1023;
      pix_x = 11'(xi); pix_y = 10'(yi);
      pix_valid = ($urandom_range(0, 7) != 0);
      value_load = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) value = VALUE_W'($urandom_range(9990, 10010));
      else if ($urandom_range(0, 1) == 0) value = VALUE_W'($urandom_range(0, 120));
      else value = VALUE_W'($urandom_range(0, 16383));
      if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
    end
    value_load = 1'b0;
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/score_digit_renderer.md
# score_digit_renderer

Parametrised multi-digit decimal score renderer for the playfield video path. Accepts a binary score value, converts it to BCD with a sequential double-dabble engine, then, per pixel from the video timing generator, outputs whether the pixel lies on a lit glyph bit. Glyphs use the team's 8x8 digit font, scaled by a power of two, with leading-zero blanking. It replaces the single-digit, fixed-size glyph lookup.

## Interface
- DIGITS, 4: number of decimal digits displayed (1..8).
- VALUE_W, 14: width of the binary score input.
- SCALE_SHIFT, 1: each font pixel is drawn as a (2^SCALE_SHIFT)-pixel square on screen.
- BLANK_LEADING, 1: 1 = suppress leading zeros (least-significant digit always drawn).

- clk  in  1  pixel/system clock; one clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- value  in  VALUE_W  binary score; sampled on an accepted load.
- value_load  in  1  single-cycle load request.
- busy  out  1  conversion in progress; loads ignored while high.
- overflow  out  1  last committed value exceeded 10^DIGITS-1 and was saturated.
- origin_x  in  11  screen x of the left edge of the leftmost digit.
- origin_y  in  10  screen y of the top edge of the digits.
- pix_x  in  11  current pixel x.
- pix_y  in  10  current pixel y.
- pix_valid  in  1  pix_x/pix_y are valid (active video).
- pix_on  out  1  pixel is a lit glyph bit.
- pix_on_valid  out  1  pix_valid delayed to align with pix_on.

## Operation
- FSM states: IDLE, CONVERT, COMMIT.
- IDLE: value_load=1 → capture value into the shift register, go to CONVERT. If value > 10^DIGITS-1, capture 10^DIGITS-1 instead and set the pending-overflow flag.
- CONVERT: VALUE_W iterations, one per cycle. Each iteration adds 3 to every BCD nibble >= 5, then shifts the combined BCD/binary register left by one bit in the same cycle. After the last iteration go to COMMIT.
- COMMIT: copy the 4*DIGITS BCD result and the pending-overflow flag into the display register and overflow in one cycle, then go to IDLE.
- value_load while busy is ignored and not queued.
- Renderer always reads the display register, so the old digits stay on screen until COMMIT.
- Digit box: width DIGITS*8<<SCALE_SHIFT, height 8<<SCALE_SHIFT.
- Position decode: dx=pix_x-origin_x and dy=pix_y-origin_y, computed signed at 12/11 bits. Pixels outside the box (negative or too large) give pix_on=0.
- Field extraction:
  - digit index = dx>>(3+SCALE_SHIFT); index 0 is the most significant (leftmost) digit.
  - col = (dx>>SCALE_SHIFT)&7.
  - row = (dy>>SCALE_SHIFT)&7.
  - pix_on = font[digit][row] bit (7-col); the MSB is the leftmost pixel.
- Blanking: a digit is blank if it is zero and every digit to its left is zero, except index DIGITS-1. Blank digits and non-decimal nibbles give pix_on=0.
- Font rows 0..7, hex:
  - 0: 3C 66 66 66 66 66 3C 00
  - 1: 18 38 18 18 18 18 7E 00
  - 2: 3C 66 06 0C 30 60 7E 00
  - 3: 3C 66 06 1C 06 66 3C 00
  - 4: 0C 1C 3C 6C 7E 0C 1E 00
  - 5: 7E 60 7C 06 06 66 3C 00
  - 6: 3C 66 60 7C 66 66 3C 00
  - 7: 7E 66 06 0C 18 18 18 00
  - 8: 3C 66 66 3C 66 66 3C 00
  - 9: 3C 66 66 3E 06 66 3C 00
- pix_valid=0 forces pix_on=0.

## Timing
- Reset values (asynchronous, immediate): FSM=IDLE, busy=0, overflow=0, display register=all zeros (the screen shows a single "0"), pix_on=0, pix_on_valid=0, and both render pipeline stages cleared.
- Load accepted at edge t:
  - busy=1 for cycles t+1 .. t+VALUE_W+1 (VALUE_W CONVERT cycles plus 1 COMMIT cycle).
  - The display register and overflow update at the edge ending COMMIT.
  - busy=0 from the following cycle, and a new load is accepted in that same cycle.
- Render pipeline is 2 registered stages:
  - Stage 1: box test and digit/row/col decode, using origin values sampled together with the pixel.
  - Stage 2: font lookup.
  - pix_on and pix_on_valid appear 2 cycles after pix_x/pix_y/pix_valid, with fully pipelined throughput of 1 pixel/cycle.
- The display register switching mid-frame is permitted; a pixel in stage 1 at the commit edge may use either the old or the new digits.
- Reset asserted mid-conversion aborts it: no commit happens, and all outputs return to their reset values.

## Test plan
(Defaults: DIGITS=4, VALUE_W=14, SCALE_SHIFT=1; origin (100,50).)
- Reset, no load, scan pixels:
  - (152,50) → pix_on=1 two cycles later (digit 3, '0' row 0 col 2).
  - (104,50) → pix_on=0 (digit 0 blanked).
- Load 1234:
  - busy high exactly 15 cycles, overflow=0.
  - (104,52) → 1 ('1' row 1 col 2).
  - (114,52) → 0 (col 7).
- Load 12000 → the display reads 9999 and overflow=1; then load 5 → the display reads "   5" and overflow=0.
- Load 42, then pulse value_load with 7 three cycles later:
  - The second load is ignored; the final display is 42.
  - Pixels sampled during the conversion render the previous value.
- Boundaries: pix_x=99, pix_x=164, and pix_y=66 → pix_on=0. pix_valid=0 → pix_on_valid=0 and pix_on=0, two cycles later.
- Load 9999, then assert rst_n low at cycle 5 of busy:
  - busy=0 and overflow=0 immediately.
  - After release the display is "0", and (152,50) → 1.
